// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl : rv32i 5-stage hazard control (forwarding, load-use stall,
//                    branch flush, dmem wait freeze). Option: PIPE_HAZ_PERF_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5
`ifdef PIPE_HAZ_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
`ifdef PIPE_HAZ_PERF_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      wait_cnt,
`endif
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t state_q;

  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic [REG_ADDR_W-1:0] ex_rd_d, ex_rs1_d, ex_rs2_d;
  logic                  ex_uses_rs1_q, ex_uses_rs2_q, ex_reg_write_q, ex_mem_read_q, ex_mem_write_q;
  logic                  ex_uses_rs1_d, ex_uses_rs2_d, ex_reg_write_d, ex_mem_read_d, ex_mem_write_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_reg_write_q, mem_mem_read_q, mem_mem_write_q;
  logic                  mem_reg_write_d, mem_mem_read_d, mem_mem_write_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_reg_write_q, wb_reg_write_d;

  logic w_mem_acc;
  logic w_freeze;
  logic w_branch;
  logic w_load_use;
  logic w_ex_bubble;

  assign w_mem_acc = mem_mem_read_q | mem_mem_write_q;
  assign w_freeze  = ~dmem_ready & (w_mem_acc | (state_q == ST_MEM_WAIT));
  // rst_n gate keeps both flushes low while reset is asserted
  assign w_branch  = rst_n & ex_branch_taken & ~w_freeze;

  assign w_load_use = ~w_freeze & ~ex_branch_taken & ex_mem_read_q
                    & (ex_rd_q != '0)
                    & ((id_uses_rs1 & (id_rs1 == ex_rd_q)) | (id_uses_rs2 & (id_rs2 == ex_rd_q)));

  assign w_ex_bubble = w_branch | w_load_use;

  assign pc_en       = ~w_freeze & ~w_load_use;
  assign if_id_en    = ~w_freeze & ~w_load_use;
  assign if_id_flush = w_branch;
  assign id_ex_en    = ~w_freeze;
  assign id_ex_flush = w_ex_bubble;
  assign ex_mem_en   = ~w_freeze;
  assign mem_wb_en   = ~w_freeze;

  // MEM beats WB; a write to x0 is never a forwarding source
  assign fwd_a_sel =
      (ex_uses_rs1_q & mem_reg_write_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs1_q)) ? 2'b01 :
      (ex_uses_rs1_q & wb_reg_write_q  & (wb_rd_q  != '0) & (wb_rd_q  == ex_rs1_q)) ? 2'b10 :
      2'b00;
  assign fwd_b_sel =
      (ex_uses_rs2_q & mem_reg_write_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs2_q)) ? 2'b01 :
      (ex_uses_rs2_q & wb_reg_write_q  & (wb_rd_q  != '0) & (wb_rd_q  == ex_rs2_q)) ? 2'b10 :
      2'b00;

  always_comb begin
    ex_rd_d         = ex_rd_q;
    ex_rs1_d        = ex_rs1_q;
    ex_rs2_d        = ex_rs2_q;
    ex_uses_rs1_d   = ex_uses_rs1_q;
    ex_uses_rs2_d   = ex_uses_rs2_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_mem_write_d  = ex_mem_write_q;
    mem_rd_d        = mem_rd_q;
    mem_reg_write_d = mem_reg_write_q;
    mem_mem_read_d  = mem_mem_read_q;
    mem_mem_write_d = mem_mem_write_q;
    wb_rd_d         = wb_rd_q;
    wb_reg_write_d  = wb_reg_write_q;
    if (!w_freeze) begin
      wb_rd_d         = mem_rd_q;
      wb_reg_write_d  = mem_reg_write_q;
      mem_rd_d        = ex_rd_q;
      mem_reg_write_d = ex_reg_write_q;
      mem_mem_read_d  = ex_mem_read_q;
      mem_mem_write_d = ex_mem_write_q;
      if (w_ex_bubble) begin
        ex_rd_d        = '0;
        ex_rs1_d       = '0;
        ex_rs2_d       = '0;
        ex_uses_rs1_d  = 1'b0;
        ex_uses_rs2_d  = 1'b0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
      end else begin
        ex_rd_d        = id_rd;
        ex_rs1_d       = id_rs1;
        ex_rs2_d       = id_rs2;
        ex_uses_rs1_d  = id_uses_rs1;
        ex_uses_rs2_d  = id_uses_rs2;
        ex_reg_write_d = id_reg_write;
        ex_mem_read_d  = id_mem_read;
        ex_mem_write_d = id_mem_write;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q         <= '0;
      ex_rs1_q        <= '0;
      ex_rs2_q        <= '0;
      ex_uses_rs1_q   <= 1'b0;
      ex_uses_rs2_q   <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      mem_mem_write_q <= 1'b0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
    end else begin
      ex_rd_q         <= ex_rd_d;
      ex_rs1_q        <= ex_rs1_d;
      ex_rs2_q        <= ex_rs2_d;
      ex_uses_rs1_q   <= ex_uses_rs1_d;
      ex_uses_rs2_q   <= ex_uses_rs2_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      mem_rd_q        <= mem_rd_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_mem_read_q  <= mem_mem_read_d;
      mem_mem_write_q <= mem_mem_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:      if (w_mem_acc && !dmem_ready) state_q <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (dmem_ready) state_q <= ST_RUN;
        default:     state_q <= ST_RUN;
      endcase
    end
  end

`ifdef PIPE_HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (w_load_use && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (w_branch   && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (w_freeze   && (wait_cnt_q  != '1)) wait_cnt_q  <= wait_cnt_q  + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// tb_pipe_hazard_ctrl : directed vector table, corner sequences and a random
// run against a pipeline-array reference model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       rw;
    logic       mr;
    logic       mw;
  } ins_t;

  typedef struct {
    ins_t       id;
    logic       br;
    logic       rdy;
    logic [6:0] en;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [6:0] EN_RUN = 7'b1101011;
  localparam logic [6:0] EN_LU  = 7'b0001111;
  localparam logic [6:0] EN_BR  = 7'b1111111;
  localparam logic [6:0] EN_FRZ = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_mem_write;
  logic       ex_branch_taken, dmem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .ex_branch_taken (ex_branch_taken),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
`ifdef PIPE_HAZ_PERF_EN
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .wait_cnt        (wait_cnt),
`endif
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  ins_t pipe [3];
  int   m_stall, m_flush, m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] en_vec();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
  endfunction

  function automatic ins_t mki(input int rd, input int rs1, input int rs2, input logic [4:0] f);
    ins_t i;
    i.rd  = 5'(rd);
    i.rs1 = 5'(rs1);
    i.rs2 = 5'(rs2);
    {i.u1, i.u2, i.rw, i.mr, i.mw} = f;
    return i;
  endfunction

  function automatic vec_t mkv(input ins_t id, input logic br, input logic rdy,
                               input logic [6:0] en, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.id = id; v.br = br; v.rdy = rdy; v.en = en; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic drive(input ins_t i, input logic br, input logic rdy);
    id_rd = i.rd; id_rs1 = i.rs1; id_rs2 = i.rs2;
    id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; id_reg_write = i.rw;
    id_mem_read = i.mr; id_mem_write = i.mw;
    ex_branch_taken = br; dmem_ready = rdy;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    drive(v.id, v.br, v.rdy);
    @(negedge clk);
    chk({tag, "_en"}, 32'(en_vec()), 32'(v.en));
    chk({tag, "_fa"}, 32'(fwd_a_sel), 32'(v.fa));
    chk({tag, "_fb"}, 32'(fwd_b_sel), 32'(v.fb));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0, 1'b0, 1'b1);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    m_stall = 0; m_flush = 0; m_wait = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic u);
    if (!u || r == 5'd0) return 2'b00;
    if (pipe[1].rw && pipe[1].rd == r) return 2'b01;
    if (pipe[2].rw && pipe[2].rd == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic rand_cycle();
    ins_t       id;
    logic       br, rdy, frz, brk, lu;
    logic [6:0] e;
    int         kind;
    id.rd  = 5'($urandom_range(0, 3));
    id.rs1 = 5'($urandom_range(0, 3));
    id.rs2 = 5'($urandom_range(0, 3));
    id.u1  = 1'($urandom_range(0, 1));
    id.u2  = 1'($urandom_range(0, 1));
    kind   = int'($urandom_range(0, 3));
    id.mr  = (kind == 0);
    id.mw  = (kind == 1);
    id.rw  = (kind != 1);
    br     = ($urandom_range(0, 7) == 0);
    rdy    = ($urandom_range(0, 3) != 0);
    drive(id, br, rdy);

    frz = (pipe[1].mr | pipe[1].mw) & ~rdy;
    brk = br & ~frz;
    lu  = ~frz & ~br & pipe[0].mr & (pipe[0].rd != 5'd0)
        & ((id.u1 && id.rs1 == pipe[0].rd) || (id.u2 && id.rs2 == pipe[0].rd));
    e   = frz ? EN_FRZ : brk ? EN_BR : lu ? EN_LU : EN_RUN;

    @(negedge clk);
    chk("rnd_en", 32'(en_vec()), 32'(e));
    chk("rnd_fa", 32'(fwd_a_sel), 32'(m_fwd(pipe[0].rs1, pipe[0].u1)));
    chk("rnd_fb", 32'(fwd_b_sel), 32'(m_fwd(pipe[0].rs2, pipe[0].u2)));
`ifdef PIPE_HAZ_PERF_EN
    chk("rnd_stall_cnt", stall_cnt, 32'(m_stall));
    chk("rnd_flush_cnt", flush_cnt, 32'(m_flush));
    chk("rnd_wait_cnt",  wait_cnt,  32'(m_wait));
`endif
    @(posedge clk);
    if (lu)  m_stall++;
    if (brk) m_flush++;
    if (frz) m_wait++;
    if (!frz) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (brk || lu) ? '0 : id;
    end
    #1;
  endtask

  vec_t tbl [$];

  initial begin
    // flags are {uses_rs1, uses_rs2, reg_write, mem_read, mem_write}
    tbl.push_back(mkv(mki(3, 1, 2, 5'b11100), 0, 1, EN_RUN, 2'b00, 2'b00)); // add x3,x1,x2
    tbl.push_back(mkv(mki(4, 3, 1, 5'b11100), 0, 1, EN_RUN, 2'b00, 2'b00)); // sub x4,x3,x1
    tbl.push_back(mkv(mki(8, 9, 3, 5'b11100), 0, 1, EN_RUN, 2'b01, 2'b00)); // sub in EX
    tbl.push_back(mkv('0,                     0, 1, EN_RUN, 2'b00, 2'b10)); // and x8,x9,x3 in EX
    tbl.push_back(mkv(mki(5, 1, 0, 5'b10110), 0, 1, EN_RUN, 2'b00, 2'b00)); // lw x5
    tbl.push_back(mkv(mki(6, 5, 5, 5'b11100), 0, 1, EN_LU,  2'b00, 2'b00)); // add x6,x5,x5
    tbl.push_back(mkv(mki(6, 5, 5, 5'b11100), 0, 1, EN_RUN, 2'b00, 2'b00)); // stall released
    tbl.push_back(mkv('0,                     0, 1, EN_RUN, 2'b10, 2'b10)); // add reads lw from WB
    tbl.push_back(mkv('0,                     1, 1, EN_BR,  2'b00, 2'b00)); // branch
    tbl.push_back(mkv(mki(2, 0, 0, 5'b00100), 0, 1, EN_RUN, 2'b00, 2'b00)); // EX bubble
    tbl.push_back(mkv(mki(0, 1, 2, 5'b11001), 0, 1, EN_RUN, 2'b00, 2'b00)); // sw
    tbl.push_back(mkv(mki(10, 2, 2, 5'b11100), 0, 1, EN_RUN, 2'b00, 2'b01)); // sw in EX
    tbl.push_back(mkv('0,                     0, 0, EN_FRZ, 2'b10, 2'b10)); // sw in MEM, wait 1
    tbl.push_back(mkv('0,                     0, 0, EN_FRZ, 2'b10, 2'b10)); // wait 2
    tbl.push_back(mkv('0,                     1, 0, EN_FRZ, 2'b10, 2'b10)); // wait 3, freeze beats branch
    tbl.push_back(mkv('0,                     1, 1, EN_BR,  2'b10, 2'b10)); // ready + held branch
    tbl.push_back(mkv(mki(9, 2, 0, 5'b10110), 0, 1, EN_RUN, 2'b00, 2'b00)); // lw x9
    tbl.push_back(mkv(mki(11, 9, 0, 5'b11100), 1, 1, EN_BR, 2'b00, 2'b00)); // branch wins over load-use
    tbl.push_back(mkv(mki(0, 1, 0, 5'b10100), 0, 1, EN_RUN, 2'b00, 2'b00)); // addi x0
    tbl.push_back(mkv(mki(12, 0, 0, 5'b11100), 0, 1, EN_RUN, 2'b00, 2'b00));
    tbl.push_back(mkv(mki(0, 1, 0, 5'b10110), 0, 1, EN_RUN, 2'b00, 2'b00)); // x0 in MEM not forwarded
    tbl.push_back(mkv(mki(13, 0, 0, 5'b11100), 0, 1, EN_RUN, 2'b00, 2'b00)); // lw x0 never stalls
    tbl.push_back(mkv('0,                     0, 1, EN_RUN, 2'b00, 2'b00));

    // reset state, with a branch and a dmem wait presented during reset
    drive('0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #11;
    chk("rst_en", 32'(en_vec()), 32'(EN_RUN));
    chk("rst_fa", 32'(fwd_a_sel), 32'd0);
    chk("rst_fb", 32'(fwd_b_sel), 32'd0);
`ifdef PIPE_HAZ_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    chk("rst_wait_cnt",  wait_cnt,  32'd0);
`endif
    do_reset();

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));
`ifdef PIPE_HAZ_PERF_EN
    chk("vec_stall_cnt", stall_cnt, 32'd1);
    chk("vec_flush_cnt", flush_cnt, 32'd3);
    chk("vec_wait_cnt",  wait_cnt,  32'd3);
`endif

    do_reset();
    repeat (2000) rand_cycle();

    // async reset abandoning a dmem wait
    do_reset();
    run_vec(mkv(mki(1, 0, 0, 5'b00100), 0, 1, EN_RUN, 2'b00, 2'b00), "ar_c1");
    run_vec(mkv(mki(0, 1, 0, 5'b10001), 0, 1, EN_RUN, 2'b00, 2'b00), "ar_c2");
    run_vec(mkv(mki(2, 1, 0, 5'b10100), 0, 1, EN_RUN, 2'b01, 2'b00), "ar_c3");
    drive('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ar_frz_en", 32'(en_vec()), 32'(EN_FRZ));
    chk("ar_frz_fa", 32'(fwd_a_sel), 32'd2);
    @(posedge clk);
    #1;
    chk("ar_wait_en", 32'(en_vec()), 32'(EN_FRZ));
`ifdef PIPE_HAZ_PERF_EN
    chk("ar_wait_cnt1", wait_cnt, 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("ar_async_en", 32'(en_vec()), 32'(EN_RUN));
    chk("ar_async_fa", 32'(fwd_a_sel), 32'd0);
    chk("ar_async_fb", 32'(fwd_b_sel), 32'd0);
`ifdef PIPE_HAZ_PERF_EN
    chk("ar_async_wait_cnt", wait_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    // dmem_ready low with an empty MEM slot must not freeze once back in RUN
    run_vec(mkv('0, 0, 0, EN_RUN, 2'b00, 2'b00), "ar_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage rv32i pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow copy of the destination/control fields of the EX, MEM and WB slots.
- Drives the EX-stage operand-forwarding mux selects, the pipeline-register enables/flushes and the PC enable.
- Resolves load-use stalls, taken-branch flushes and data-memory wait states.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 32, width of the performance counters (PIPE_HAZ_PERF_EN only).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  REG_ADDR_W  ID-stage source register 1
- id_rs2  in  REG_ADDR_W  ID-stage source register 2
- id_rd  in  REG_ADDR_W  ID-stage destination register
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- id_mem_write  in  1  ID instruction is a store
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- dmem_ready  in  1  data memory completes the current MEM-stage access
- pc_en  out  1  PC register enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID load NOP
- id_ex_en  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX load bubble
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_en  out  1  MEM/WB register enable
- fwd_a_sel  out  2  EX operand A mux select: 00 regfile, 01 EX/MEM ALU result, 10 WB value
- fwd_b_sel  out  2  EX operand B mux select; same encoding
- stall_cnt  out  CNT_W  load-use stall cycles (PIPE_HAZ_PERF_EN only)
- flush_cnt  out  CNT_W  branch flush events (PIPE_HAZ_PERF_EN only)
- wait_cnt  out  CNT_W  memory wait cycles (PIPE_HAZ_PERF_EN only)

Behaviour:
- Shadow slots:
  - EX = {rd, rs1, rs2, uses_rs1, uses_rs2, reg_write, mem_read, mem_write}
  - MEM = {rd, reg_write, mem_read, mem_write}
  - WB = {rd, reg_write}
- Reset: all slots set to bubble (all fields 0); FSM goes to RUN.
- Outputs during and after reset: all enables 1, flushes 0, fwd_*_sel 00, counters 0.
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: entered when the MEM slot has mem_read|mem_write and dmem_ready=0.
  - Exit MEM_WAIT to RUN on the first cycle dmem_ready=1; that cycle is a normal RUN-type advance.
- Freeze (MEM_WAIT, or RUN with a MEM access and dmem_ready=0; same-cycle, combinational):
  - All enables 0, both flushes 0, slots hold.
  - Freeze has priority over every other event.
- Branch (not frozen, ex_branch_taken=1):
  - if_id_flush=1 and id_ex_flush=1; enables stay 1.
  - Next EX slot is a bubble.
  - Takes priority over load-use.
  - A branch asserted during freeze is acted on in the first unfrozen cycle; ex_branch_taken is held by the frozen EX stage.
- Load-use (not frozen, no branch):
  - Condition: EX.mem_read=1, EX.rd≠0, and ((id_uses_rs1 && id_rs1==EX.rd) || (id_uses_rs2 && id_rs2==EX.rd)).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1; remaining enables 1.
  - Next EX slot is a bubble. Lasts exactly 1 cycle.
- Slot advance (not frozen):
  - WB←MEM, MEM←EX.
  - EX←bubble if flushing/stalling, else EX←ID inputs.
- Forwarding (combinational from slots, valid every cycle):
  - fwd_a_sel=01 if MEM.reg_write && MEM.rd≠0 && MEM.rd==EX.rs1 && EX.uses_rs1.
  - Else fwd_a_sel=10 on the same test against WB.
  - Else 00. MEM has priority over WB.
  - fwd_b_sel uses the same rules on rs2.
  - x0 never forwarded.
- Reset mid-operation: immediate async return to reset values; the in-flight wait is abandoned.

Optional Feature:
- Macro: PIPE_HAZ_PERF_EN.
- Defined:
  - stall_cnt increments each load-use cycle.
  - flush_cnt increments each unfrozen branch cycle.
  - wait_cnt increments each frozen cycle.
  - All three saturate at all-ones and reset to 0.
- Undefined: stall_cnt, flush_cnt and wait_cnt are absent; no counter logic.

Test Plan:
- Release reset, ID "add x3,x1,x2" then "sub x4,x3,x1" -> cycle sub in EX: fwd_a_sel=01, fwd_b_sel=00; one cycle later a dependent reader of x3 in EX gets 10.
- "lw x5,0(x1)" in EX, ID "add x6,x5,x5" -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle; the next cycle add in EX has fwd_a_sel=fwd_b_sel=10; stall_cnt=1.
- ex_branch_taken=1 for one cycle -> if_id_flush=id_ex_flush=1 that cycle; EX slot a bubble next cycle (fwd sel 00); flush_cnt=1.
- Store in MEM with dmem_ready low 3 cycles -> all enables 0 for 3 cycles, slots held; ready=1 -> advance, state RUN; wait_cnt=3.
- Branch plus load-use together, then writes to x0 -> branch flush wins, no pc_en drop; x0 never forwarded (sel 00).
- Assert rst_n=0 during MEM_WAIT -> enables 1, fwd 00, counters 0 immediately, without waiting for a clock edge.
